// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and constants for the serial frame transmitter.
//   state_t      - 2-bit FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   *_LEVEL      - serial line levels for idle, start and stop bits
//   min1_clog2() - counter width helper, never narrower than one bit
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: valid/ready word handshake into the transmitter.
//   valid - source offers data
//   data  - WIDTH-bit word
//   ready - transmitter can accept a word
// Modports: master (word source), slave (transmitter).
interface serial_tx_if #(
  parameter int unsigned WIDTH = 4
);

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/serial_tx_bit_timer.sv
// serial_tx_bit_timer: enable-gated modulo-CLKS_PER_BIT tick counter.
//   clk, reset (async, active low), E (clock enable)
//   run     - count while a frame is in progress, otherwise held at 0
//   bit_end - combinational strobe on the last enabled cycle of a line bit
module serial_tx_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic E,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned TW = min1_clog2(CLKS_PER_BIT);

  logic [TW-1:0] tick;

  // Strobe only on enabled cycles so the FSM never sees a frozen bit boundary.
  assign bit_end = E && run && (tick == TW'(CLKS_PER_BIT - 1));

  // Tick counter: wraps on each bit boundary, parked at 0 while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
    end else if (E) begin
      if (!run || bit_end) begin
        tick <= '0;
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame on tx: start bit (0), WIDTH data bits LSB first, stop bit (1);
// each line bit is held CLKS_PER_BIT enabled cycles. E=0 freezes all state.
//   clk, reset (async, active low), E (clock enable)
//   bus  - slave side of the valid/data/ready word handshake
//   tx   - serial line, idle high
//   busy - frame in progress
//   done - one-cycle pulse on frame completion (stretches while E=0)
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E,
  serial_tx_if.slave  bus,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic [CW-1:0]    bit_cnt, bit_cnt_d;
  logic             ready, ready_d;
  logic             tx_d, busy_d, done_d;
  logic             bit_end;

  assign bus.ready = ready;

  serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .E       (E),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

  // State and registered outputs; everything holds while E=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      ready   <= 1'b1;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (E) begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      ready   <= ready_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state and next registered outputs, computed as if enabled.
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    ready_d   = ready;
    tx_d      = tx;
    busy_d    = busy;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (bus.valid && ready) begin
          state_d   = START;
          shift_d   = bus.data;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          tx_d      = START_LEVEL;
        end
      end

      START: begin
        tx_d = START_LEVEL;
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d   = shift >> 1;
          bit_cnt_d = bit_cnt + CW'(1);
          // Line shows the next bit of the shifted word, or the stop level after the last one.
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state_d = STOP;
            tx_d    = STOP_LEVEL;
          end else begin
            tx_d    = shift_d[0];
          end
        end
      end

      STOP: begin
        tx_d = STOP_LEVEL;
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          tx_d    = IDLE_LEVEL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out frame transmitter built around an enable-gated shift register. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line: start bit (0), data LSB first, stop bit (1). Sits on the transmit side of the lab datapath, feeding a serial capture register on the far end. Shares the clock-enable convention of the DFF register family: when `E` is low, all state holds.

## Interface
- `WIDTH`, 4: data bits per frame (≥1).
- `CLKS_PER_BIT`, 1: clock-enabled cycles each line bit is held (≥1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `E`  in  1  clock enable; 0 freezes every register.
- `valid`  in  1  `data` is offered for transmission.
- `data`  in  WIDTH  word to send.
- `ready`  out  1  transmitter can accept a word.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, STOP.
- Reset (reset=0, asynchronous):
  - state=IDLE, `tx`=1, `ready`=1, `busy`=0, `done`=0.
  - Shift register, tick counter and bit counter all 0.
- Accept:
  - Rising edge with E=1, valid=1 and ready=1.
  - `data` loads into the shift register; state→START; `ready`=0, `busy`=1.
  - `valid` is ignored while `ready`=0. The word is sampled only at the accept edge.
- START: `tx`=0 for CLKS_PER_BIT enabled cycles, then →DATA with bit counter=0.
- DATA:
  - `tx` = shift_reg[0].
  - After CLKS_PER_BIT enabled cycles, shift right by one and increment the bit counter.
  - After WIDTH bits have been sent, →STOP.
- STOP: `tx`=1 for CLKS_PER_BIT enabled cycles, then →IDLE.
  - On that same edge: `done`=1 for one cycle, `ready`=1, `busy`=0.
- IDLE: `tx`=1; `done` returns to 0 on the next enabled edge.
- Enable:
  - E=0 holds state, counters, shift register and all outputs, including a `done` pulse, which therefore stretches.
  - No handshake is accepted while E=0.
- Tick counter:
  - Width is clog2(CLKS_PER_BIT), minimum 1.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Bit counter:
  - Width is clog2(WIDTH+1).
  - Never exceeds WIDTH; no wrap.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge k → `tx`=0 (start bit) is visible after edge k.
- Frame length: (WIDTH+2)·CLKS_PER_BIT enabled cycles from the accept edge to the edge raising `done`.
- Back-to-back frames:
  - `valid` may be held high; a new word is accepted on the edge after `done` rises.
  - This leaves exactly one idle-high cycle between frames when CLKS_PER_BIT=1.
- Reset mid-frame: `tx` returns to 1 immediately. No `done` is produced and the partial frame is discarded.
- Reset released while `valid`=1: the first accept occurs at the first rising edge where reset=1 and E=1.

## Structure
- Shared package/header holds:
  - State encoding: 2-bit IDLE=0, START=1, DATA=2, STOP=3.
  - Line levels: IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- Sub-module `bit_timer`:
  - Enable-gated modulo-CLKS_PER_BIT counter with async active-low reset.
  - Outputs a one-cycle `bit_end` strobe.
  - The FSM and shift register stay in `serial_tx`.

## Test plan
- Reset: hold reset=0 with valid=1 → `tx`=1, `ready`=1, `busy`=0, `done`=0 throughout. Assert reset mid-frame → `tx`=1 in the same cycle.
- Single frame, WIDTH=4, CLKS_PER_BIT=1, data=4'b1011:
  - `tx` sequence after the accept edge is 0,1,1,0,1,1 (start, data LSB first, stop).
  - `done` pulses on the 6th edge after accept.
- CLKS_PER_BIT=2, data=4'b0001: each line bit is held exactly 2 cycles; the frame takes 12 cycles.
- Enable gating: drop E to 0 for 3 cycles during DATA bit 2 → `tx` and `busy` hold; the frame finishes 3 cycles late with identical bit values.
- Back-to-back: valid held at 1 with words 4'h5 then 4'hA → second start bit begins one cycle after `done`. Changing `data` mid-frame does not affect the frame in progress.
- Ignore while busy: pulse valid with 4'hF during the STOP bit → not accepted; `ready` is 0 and no extra frame follows.
